// File: rtl/video_register_arbiter_pkg.sv
// Shared constants and state encoding for the video register write arbiter.
// VIDEO_NOP mirrors the idle index used by the video controller register file.
package video_register_arbiter_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [3:0] VIDEO_NOP = 4'h0;

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_WRITE,
        STATE_HOLDOFF
    } state_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/video_register_arbiter_rr_pick_first.sv
// Combinational round-robin search: first set bit of pending at or above ptr,
// wrapping modulo N. Shared with other register-port arbiters.
module rr_pick_first
    import video_register_arbiter_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  pending,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] idx
);

    int j;

    // Scan from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin
        found = FALSE;
        idx   = '0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (pending[j]) begin
                found = TRUE;
                idx   = PW'(j);
            end
        end
    end

endmodule

// File: rtl/video_register_arbiter.sv
// Round-robin arbiter sharing the video register write port between sources.
// Define VIDEO_ARB_OVERRUN_EN to add the sticky per-source overrun output.
module video_register_arbiter
    import video_register_arbiter_pkg::*;
#(
    parameter int REQUESTERS = 3,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [REQUESTERS-1:0]    req_ready,
    input  logic [4*REQUESTERS-1:0]  req_index,
    input  logic [23*REQUESTERS-1:0] req_value,
    input  logic                     register_busy,
    output logic                     register_write,
    output logic [3:0]               register_index,
    output logic [22:0]              register_value,
    output logic [REQUESTERS-1:0]    pending
`ifdef VIDEO_ARB_OVERRUN_EN
    ,
    output logic [REQUESTERS-1:0]    overrun
`endif
);

    localparam int PW = ptr_width(REQUESTERS);

    state_t                  state_q, state_d;
    logic [REQUESTERS-1:0]   pend_q, pend_d;
    logic [REQUESTERS-1:0]   ovr_q, ovr_d;
    logic [3:0]              slot_idx_q [REQUESTERS];
    logic [3:0]              slot_idx_d [REQUESTERS];
    logic [22:0]             slot_val_q [REQUESTERS];
    logic [22:0]             slot_val_d [REQUESTERS];
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [PW-1:0]           gnt_q, gnt_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    logic [3:0]              idx_q, idx_d;
    logic [22:0]             val_q, val_d;

    logic                    found;
    logic [PW-1:0]           pick;
    logic                    grant;

    rr_pick_first #(
        .N  (REQUESTERS),
        .PW (PW)
    ) u_pick (
        .pending (pend_q),
        .ptr     (ptr_q),
        .found   (found),
        .idx     (pick)
    );

    assign grant = (state_q == STATE_IDLE) && found && !register_busy;

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        ovr_d      = ovr_q;
        slot_idx_d = slot_idx_q;
        slot_val_d = slot_val_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        wr_d       = FALSE;
        idx_d      = VIDEO_NOP;
        val_d      = '0;

        // A strobe on the grant edge refills the slot after the old data leaves.
        for (int i = 0; i < REQUESTERS; i++) begin
            if (grant && pick == PW'(i)) pend_d[i] = FALSE;
            if (req_ready[i]) begin
                slot_idx_d[i] = req_index[4*i +: 4];
                slot_val_d[i] = req_value[23*i +: 23];
                pend_d[i]     = TRUE;
                if (pend_q[i] && !(grant && pick == PW'(i))) ovr_d[i] = TRUE;
            end
        end

        unique case (state_q)
            STATE_IDLE: begin
                if (grant) begin
                    state_d = STATE_WRITE;
                    gnt_d   = pick;
                    wr_d    = TRUE;
                    idx_d   = slot_idx_q[pick];
                    val_d   = slot_val_q[pick];
                end
            end
            STATE_WRITE: begin
                ptr_d = (gnt_q == PW'(REQUESTERS - 1)) ? '0 : gnt_q + 1'b1;
                if (GAP_CYCLES == 0) begin
                    state_d = STATE_IDLE;
                end else begin
                    state_d = STATE_HOLDOFF;
                    cnt_d   = 4'(GAP_CYCLES - 1);
                end
            end
            STATE_HOLDOFF: begin
                if (cnt_q == 4'd0) state_d = STATE_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STATE_IDLE;
            pend_q  <= '0;
            ovr_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            wr_q    <= FALSE;
            idx_q   <= VIDEO_NOP;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
        end
    end

    // Slot payloads are only meaningful while pending, so they need no reset.
    always_ff @(posedge clk) begin
        slot_idx_q <= slot_idx_d;
        slot_val_q <= slot_val_d;
    end

    assign register_write = wr_q;
    assign register_index = idx_q;
    assign register_value = val_q;
    assign pending        = pend_q;
`ifdef VIDEO_ARB_OVERRUN_EN
    assign overrun        = ovr_q;
`endif

endmodule

// File: tb/tb_video_register_arbiter.sv
// Scoreboard bench for video_register_arbiter (REQUESTERS=3, GAP_CYCLES=2).
module tb_video_register_arbiter;
    import video_register_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req_ready = '0;
    logic [11:0] req_index = '0;
    logic [68:0] req_value = '0;
    logic        register_busy = 1'b0;
    logic        register_write;
    logic [3:0]  register_index;
    logic [22:0] register_value;
    logic [2:0]  pending;
`ifdef VIDEO_ARB_OVERRUN_EN
    logic [2:0]  overrun;
`endif

    typedef struct {
        int          cyc;
        logic [3:0]  idx;
        logic [22:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [3:0]  idx_a[3];
    logic [22:0] val_a[3];

    video_register_arbiter #(
        .REQUESTERS (3),
        .GAP_CYCLES (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_ready      (req_ready),
        .req_index      (req_index),
        .req_value      (req_value),
        .register_busy  (register_busy),
        .register_write (register_write),
        .register_index (register_index),
        .register_value (register_value),
        .pending        (pending)
`ifdef VIDEO_ARB_OVERRUN_EN
        ,
        .overrun        (overrun)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pop the expected write whenever the DUT issues one.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && register_write === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write cyc=%0d got idx=%h val=%h, required no write",
                         cyc, register_index, register_value);
            end else begin
                e = exp_q.pop_front();
                if (register_index !== e.idx || register_value !== e.val || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL write got cyc=%0d idx=%h val=%h, required cyc=%0d idx=%h val=%h",
                             cyc, register_index, register_value, e.cyc, e.idx, e.val);
                end
            end
        end
    end

    task automatic pulse(input logic [2:0] m, output int t);
        @(negedge clk);
        req_ready = m;
        req_index = {idx_a[2], idx_a[1], idx_a[0]};
        req_value = {val_a[2], val_a[1], val_a[0]};
        @(posedge clk);
        #1;
        t = cyc;
        req_ready = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (register_write !== 1'b0) begin
            failures++;
            $display("FAIL reset_write got %b required 0", register_write);
        end
        checks++;
        if (register_index !== VIDEO_NOP) begin
            failures++;
            $display("FAIL reset_index got %h required %h", register_index, VIDEO_NOP);
        end
        checks++;
        if (register_value !== 23'd0) begin
            failures++;
            $display("FAIL reset_value got %h required 0", register_value);
        end
        checks++;
        if (pending !== 3'b000) begin
            failures++;
            $display("FAIL reset_pending got %b required 000", pending);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        int t;
        idx_a[1] = 4'hA;
        val_a[1] = 23'h12345;
        pulse(3'b010, t);
        exp_q.push_back('{t + 1, 4'hA, 23'h12345});
        checks++;
        if (pending !== 3'b010) begin
            failures++;
            $display("FAIL single_pending got %b required 010", pending);
        end
        @(negedge clk);
        checks++;
        if (register_write !== 1'b0) begin
            failures++;
            $display("FAIL single_early got %b required 0", register_write);
        end
        @(negedge clk);
        checks++;
        if (pending !== 3'b000) begin
            failures++;
            $display("FAIL single_cleared got %b required 000", pending);
        end
        @(negedge clk);
        checks++;
        if (register_write !== 1'b0 || register_index !== VIDEO_NOP || register_value !== 23'd0) begin
            failures++;
            $display("FAIL single_idle got w=%b idx=%h val=%h required 0/%h/0",
                     register_write, register_index, register_value, VIDEO_NOP);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL single_missing got %0d left required 0", exp_q.size());
        end
    endtask

    task automatic test_contention();
        int t;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                idx_a[i] = 4'(i + 1 + 4 * r);
                val_a[i] = 23'(100 * (i + 1) + r);
            end
            pulse(3'b111, t);
            for (int i = 0; i < 3; i++)
                exp_q.push_back('{t + 1 + 4 * i, idx_a[i], val_a[i]});
            repeat (14) @(negedge clk);
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL contention_missing round=%0d got %0d left required 0", r, exp_q.size());
            end
        end
    endtask

    task automatic test_overwrite();
        int t, t2, t3;
        idx_a[2] = 4'h5;
        val_a[2] = 23'h222;
        pulse(3'b100, t);
        exp_q.push_back('{t + 1, 4'h5, 23'h222});
        idx_a[0] = 4'h6;
        val_a[0] = 23'd5;
        pulse(3'b001, t2);
        val_a[0] = 23'd7;
        pulse(3'b001, t3);
        exp_q.push_back('{t + 5, 4'h6, 23'd7});
        repeat (10) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL overwrite_missing got %0d left required 0", exp_q.size());
        end
`ifdef VIDEO_ARB_OVERRUN_EN
        checks++;
        if (overrun !== 3'b001) begin
            failures++;
            $display("FAIL overwrite_overrun got %b required 001", overrun);
        end
`endif
    endtask

    task automatic test_busy();
        int t;
        idx_a[2] = 4'h9;
        val_a[2] = 23'h7abcd;
        register_busy = 1'b1;
        pulse(3'b100, t);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (register_write !== 1'b0) begin
                failures++;
                $display("FAIL busy_write cycle=%0d got %b required 0", i, register_write);
            end
        end
        checks++;
        if (pending[2] !== 1'b1) begin
            failures++;
            $display("FAIL busy_pending got %b required 1", pending[2]);
        end
        exp_q.push_back('{cyc + 1, 4'h9, 23'h7abcd});
        register_busy = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL busy_missing got %0d left required 0", exp_q.size());
        end
    endtask

    task automatic test_regrant();
        int t, t2;
        idx_a[1] = 4'h3;
        val_a[1] = 23'd3;
        pulse(3'b010, t);
        exp_q.push_back('{t + 1, 4'h3, 23'd3});
        val_a[1] = 23'd9;
        pulse(3'b010, t2);
        exp_q.push_back('{t + 5, 4'h3, 23'd9});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (pending[1] !== 1'b1) begin
                failures++;
                $display("FAIL regrant_pending cycle=%0d got %b required 1", i, pending[1]);
            end
        end
        repeat (6) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL regrant_missing got %0d left required 0", exp_q.size());
        end
`ifdef VIDEO_ARB_OVERRUN_EN
        checks++;
        if (overrun[1] !== 1'b0) begin
            failures++;
            $display("FAIL regrant_overrun got %b required 0", overrun[1]);
        end
`endif
    endtask

    task automatic test_reset_holdoff();
        int t, t2;
        idx_a[1] = 4'h1;
        val_a[1] = 23'd11;
        pulse(3'b010, t);
        exp_q.push_back('{t + 1, 4'h1, 23'd11});
        idx_a[0] = 4'hC;
        val_a[0] = 23'd21;
        idx_a[2] = 4'hD;
        val_a[2] = 23'd22;
        pulse(3'b101, t2);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (pending !== 3'b000 || register_write !== 1'b0) begin
            failures++;
            $display("FAIL holdoff_reset got pending=%b w=%b required 000/0", pending, register_write);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (register_write !== 1'b0) begin
                failures++;
                $display("FAIL holdoff_after_reset cycle=%0d got %b required 0", i, register_write);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL holdoff_missing got %0d left required 0", exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            idx_a[i] = '0;
            val_a[i] = '0;
        end
        test_reset();
        test_single();
        test_contention();
        test_overwrite();
        test_busy();
        test_regrant();
        test_reset_holdoff();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
